// File: rtl/serial_subtractor_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_subtractor_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_e;
  localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/full_subtractor_1bit.sv
// Combinational 1-bit full subtractor: a - b - borrow.
module full_subtractor_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic borrow_i,
  output logic diff_o,
  output logic borrow_o
);
  assign diff_o   = a_i ^ b_i ^ borrow_i;
  assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with valid/ready on both sides.
// Define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             borrow_in,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic             borrow_out
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
  logic             br_q, br_d, bout_q, bout_d;
  logic             fs_diff, fs_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  full_subtractor_1bit u_fs (
    .a_i      (a_q[cnt_q]),
    .b_i      (b_q[cnt_q]),
    .borrow_i (br_q),
    .diff_o   (fs_diff),
    .borrow_o (fs_borrow)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: if (in_valid) begin
        a_d     = data_a;
        b_d     = data_b;
        br_d    = borrow_in;
        cnt_d   = '0;
        diff_d  = '0;
        state_d = RUN;
      end
      RUN: begin
        diff_d[cnt_q] = fs_diff;
        br_d          = fs_borrow;
        cnt_d         = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d = DONE;
          cnt_d   = '0;
          bout_d  = fs_borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // fs_diff is the MSB of the result on this final cycle
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (fs_diff != a_q[WIDTH-1]);
`endif
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Reset masks in_ready so no operand is offered while the block is held.
  assign in_ready   = (state_q == IDLE) && !reset;
  assign out_valid  = (state_q == DONE);
  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign overflow   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor against an arithmetic model.
module tb_serial_subtractor;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, borrow_in, out_valid, out_ready, borrow_out;
  logic [W-1:0] data_a, data_b, diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .borrow_in  (borrow_in),
    .data_a     (data_a),
    .data_b     (data_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow   (overflow),
`endif
    .borrow_out (borrow_out)
  );

  // Reference: plain integer arithmetic on the unsigned operands.
  function automatic logic [W-1:0] ref_diff(input logic [W-1:0] a, b, input logic bin);
    int r;
    r = int'(a) - int'(b) - int'(bin) + (1 << W);
    return W'(r % (1 << W));
  endfunction

  function automatic logic ref_borrow(input logic [W-1:0] a, b, input logic bin);
    return int'(a) < int'(b) + int'(bin);
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a, b, input logic bin);
    logic [W-1:0] d;
    d = ref_diff(a, b, bin);
    return (a[W-1] != b[W-1]) && (d[W-1] != a[W-1]);
  endfunction

  task automatic scramble_inputs();
    in_valid  = 1'($urandom);
    data_a    = W'($urandom);
    data_b    = W'($urandom);
    borrow_in = 1'($urandom);
  endtask

  // One full operation: accept, RUN with noisy inputs, DONE held for hold cycles, handshake.
  task automatic run_op(input logic [W-1:0] a, b, input logic bin, input int hold, input string tag);
    logic [W-1:0] ed, held;
    logic eb;
    ed = ref_diff(a, b, bin);
    eb = ref_borrow(a, b, bin);
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL %s in_ready_idle got=%b want=1", tag, in_ready); else n_pass++;
    in_valid = 1'b1; data_a = a; data_b = b; borrow_in = bin; out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) $display("FAIL %s in_ready_run got=%b want=0", tag, in_ready); else n_pass++;
    scramble_inputs();
    for (int i = 1; i < W; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL %s early_out_valid cyc=%0d got=%b want=0", tag, i, out_valid); else n_pass++;
      scramble_inputs();
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) $display("FAIL %s out_valid_latency got=%b want=1", tag, out_valid); else n_pass++;
    n_checks++;
    if (diff !== ed) $display("FAIL %s diff a=%h b=%h bin=%b got=%h want=%h", tag, a, b, bin, diff, ed); else n_pass++;
    n_checks++;
    if (borrow_out !== eb) $display("FAIL %s borrow_out got=%b want=%b", tag, borrow_out, eb); else n_pass++;
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_checks++;
    if (overflow !== ref_ovf(a, b, bin)) $display("FAIL %s overflow got=%b want=%b", tag, overflow, ref_ovf(a, b, bin)); else n_pass++;
`endif
    held = diff;
    for (int i = 0; i < hold; i++) begin
      scramble_inputs();
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || diff !== ed || borrow_out !== eb)
        $display("FAIL %s hold cyc=%0d ov=%b ir=%b diff=%h bo=%b want ov=1 ir=0 diff=%h bo=%b",
                 tag, i, out_valid, in_ready, diff, borrow_out, ed, eb);
      else n_pass++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || diff !== held)
      $display("FAIL %s handshake ov=%b ir=%b diff=%h want ov=0 ir=1 diff=%h", tag, out_valid, in_ready, diff, held);
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_a = '0; data_b = '0; borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || diff !== '0 || borrow_out !== 1'b0)
      $display("FAIL reset_state ir=%b ov=%b diff=%h bo=%b want all 0", in_ready, out_valid, diff, borrow_out);
    else n_pass++;
`ifdef SERIAL_SUB_OVERFLOW_EN
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow got=%b want=0", overflow); else n_pass++;
`endif
    reset = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready got=%b want=1", in_ready); else n_pass++;
  endtask

  task automatic test_directed();
    run_op(4'b0011, 4'b0001, 1'b0, 0, "dir_3m1");
    run_op(4'b0001, 4'b0011, 1'b0, 0, "dir_1m3");
    run_op(4'b0000, 4'b0000, 1'b1, 0, "dir_0m0b");
    run_op(4'b1000, 4'b0001, 1'b0, 0, "dir_ovf");
    run_op(4'b1111, 4'b1111, 1'b1, 0, "dir_ffb");
    run_op(4'b0111, 4'b1000, 1'b0, 0, "dir_ovf2");
  endtask

  task automatic test_backpressure();
    run_op(4'b1010, 4'b0011, 1'b1, 3, "bp_hold3");
  endtask

  task automatic test_random();
    for (int k = 0; k < 40; k++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 2)), "rand");
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    in_valid = 1'b1; data_a = 4'b1101; data_b = 4'b0100; borrow_in = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || diff !== '0 || in_ready !== 1'b0)
      $display("FAIL reset_mid_run ov=%b diff=%h ir=%b want ov=0 diff=0 ir=0", out_valid, diff, in_ready);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
        $display("FAIL reset_abort_idle cyc=%0d ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
      else n_pass++;
    end
    run_op(4'b0110, 4'b0010, 1'b0, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
